// File: rtl/sram_like_responder.sv
// ============================================================================
// Module : sram_like_responder
// Brief  : Responder end of the sram-like req/addr_ok/data_ok protocol, backed
//          by a word-addressed memory with in-order, fixed-latency responses.
//          Optional random accept/latency jitter when RANDOM_DELAY_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_like_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 4,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(LATENCY + 4);

  logic [31:0]   r_mem  [0:(2**ADDR_W)-1];
  logic [31:0]   r_data [0:DEPTH-1];
  logic [WW-1:0] r_wait [0:DEPTH-1];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_data_ok;
  logic [31:0]   r_rdata;

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_extra;
  logic              w_gate;
  logic              w_accept;
  logic [WW-1:0]     w_w0;
  logic [WW-1:0]     w_store_wait;
  logic [31:0]       w_push_data;
  logic              w_head_ready;
  logic              w_bypass;
  logic              w_push_store;
  logic [PW-1:0]     w_wr_ptr_nxt;
  logic [PW-1:0]     w_rd_ptr_nxt;
  logic              w_unused;

`ifdef RANDOM_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_gate   = r_lfsr[0];
  assign w_extra  = r_lfsr[2:1];
  assign w_unused = ^{i_size, i_addr[31:ADDR_W+2], i_addr[1:0]};
`else
  assign w_gate   = 1'b1;
  assign w_extra  = 2'b00;
  assign w_unused = ^{i_size, i_addr[31:ADDR_W+2], i_addr[1:0], LFSR_SEED[0]};
`endif

  assign w_idx     = i_addr[ADDR_W+1:2];
  assign o_addr_ok = i_req & (r_count < CW'(DEPTH)) & ~reset & w_gate;
  assign w_accept  = o_addr_ok;

  // w_w0 is the countdown as seen in the accept cycle; the stored value is one
  // lower because the accept cycle itself already counts as a waited cycle.
  assign w_w0         = WW'(LATENCY - 1) + WW'(w_extra);
  assign w_store_wait = (w_w0 == '0) ? '0 : (w_w0 - WW'(1));
  assign w_push_data  = i_wr ? 32'h0 : r_mem[w_idx];

  assign w_head_ready = (r_count != '0) && (r_wait[r_rd_ptr] == '0);
  // An empty queue with zero wait responds straight from the accept edge.
  assign w_bypass     = (r_count == '0) && w_accept && (w_w0 == '0);
  assign w_push_store = w_accept && !w_bypass;

  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : (r_wr_ptr + PW'(1));
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : (r_rd_ptr + PW'(1));

  always_ff @(posedge clk) begin
    if (w_accept && i_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wait[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_wait[i] != '0) begin
          r_wait[i] <= r_wait[i] - WW'(1);
        end
      end
      if (w_push_store) begin
        r_data[r_wr_ptr] <= w_push_data;
        r_wait[r_wr_ptr] <= w_store_wait;
        r_wr_ptr         <= w_wr_ptr_nxt;
      end
      if (w_head_ready) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_data_ok <= w_head_ready || w_bypass;
      if (w_head_ready) begin
        r_rdata <= r_data[r_rd_ptr];
      end else if (w_bypass) begin
        r_rdata <= w_push_data;
      end else begin
        r_rdata <= 32'h0;
      end
      r_count <= r_count + CW'(w_push_store) - CW'(w_head_ready);
    end
  end

  assign o_data_ok = r_data_ok;
  assign o_rdata   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_like_responder.sv
// ============================================================================
// Module : tb_sram_like_responder
// Brief  : Directed and random stimulus against a transaction-level model of
//          the responder (memory array plus in-order response queue).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_like_responder;

  localparam int AW  = 10;
  localparam int DEP = 4;
  localparam int LAT = 5;
  localparam int NC  = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  sram_like_responder #(
    .ADDR_W   (AW),
    .DEPTH    (DEP),
    .LATENCY  (LAT),
    .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (req),
    .i_wr     (wr),
    .i_size   (size),
    .i_wstrb  (wstrb),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_addr_ok(addr_ok),
    .o_data_ok(data_ok),
    .o_rdata  (rdata)
  );

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          done;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] obs_rsp[$];
  logic [31:0] mem_m [0:(2**AW)-1];
  logic        obs_ao  [0:NC-1];
  logic        obs_dok [0:NC-1];
  logic [31:0] obs_rd  [0:NC-1];
  int          cyc;
  int          last_done;
  int          vectors;
  int          miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, compare at negedge, then advance the model across the edge.
  task automatic step(input logic rst, input logic r, input logic w, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] d, input bit chk,
                      output bit acc);
    rsp_t        e;
    logic [AW-1:0] idx;
    int          gap;
    reset = rst; req = r; wr = w; size = 2'($urandom); wstrb = st; addr = a; wdata = d;
    @(negedge clk);
    if (cyc < NC) begin
      obs_ao[cyc] = addr_ok; obs_dok[cyc] = data_ok; obs_rd[cyc] = rdata;
    end
    if (chk && data_ok === 1'b1) obs_rsp.push_back(rdata);
`ifndef RANDOM_DELAY_EN
    begin
      bit exp_dok;
      exp_dok = (q.size() > 0) && (q[0].done == cyc);
      if (chk) begin
        check("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
        if (exp_dok) check("rdata", rdata, q[0].data);
      end
      if (exp_dok) void'(q.pop_front());
      acc = r && !rst && (q.size() < DEP);
      if (chk) check("addr_ok", {31'b0, addr_ok}, {31'b0, acc});
    end
`else
    if (chk && data_ok === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_data_ok", {31'b0, data_ok}, 32'h0);
      end else begin
        gap = cyc - q[0].acc;
        check("rdata", rdata, q[0].data);
        check("gap_in_range", {31'b0, (gap >= LAT) && (gap <= LAT + 3)}, 32'h1);
        void'(q.pop_front());
      end
    end
    if (q.size() > 0 && (cyc - q[0].acc) > LAT + 3) begin
      check("response_timeout", {31'b0, data_ok}, 32'h1);
      void'(q.pop_front());
    end
    if (chk && addr_ok === 1'b1 && (rst || !r || q.size() >= DEP))
      check("addr_ok_illegal", {31'b0, addr_ok}, 32'h0);
    acc = (addr_ok === 1'b1) && r && !rst;
`endif
    if (acc) begin
      idx = a[AW+1:2];
      e.acc = cyc;
      if (w) begin
        e.data = 32'h0;
        for (int b = 0; b < 4; b++)
          if (st[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.data = mem_m[idx];
      end
      e.done = (cyc + LAT > last_done + 1) ? cyc + LAT : last_done + 1;
      last_done = e.done;
      q.push_back(e);
    end
    if (rst) begin
      q.delete();
      last_done = -100;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic xfer(input logic w, input logic [3:0] st, input logic [31:0] a,
                      input logic [31:0] d);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1'b0, 1'b1, w, st, a, d, 1'b1, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    int t;
    int nrsp;
    vectors = 0; miscompares = 0; cyc = 0; last_done = -100;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b10; wstrb = 4'h0; addr = 0; wdata = 0;
    #1;
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acc);
    idle(1);
    check("reset_data_ok", {31'b0, obs_dok[cyc-1]}, 32'h0);
    check("reset_rdata", obs_rd[cyc-1], 32'h0);

    for (int i = 0; i < 16; i++)
      xfer(1'b1, 4'hF, ($urandom & 32'hFFFF_F000) | (i << 2), $urandom);
    idle(LAT + 3);

    // Write then read the same word on consecutive accepts.
    t = cyc;
    xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    xfer(1'b0, 4'h0, 32'h10, 32'h0);
    idle(LAT + 3);
`ifndef RANDOM_DELAY_EN
    check("t1_no_early", {31'b0, obs_dok[t+4]}, 32'h0);
    check("t1_wr_dok", {31'b0, obs_dok[t+5]}, 32'h1);
    check("t1_wr_rdata", obs_rd[t+5], 32'h0);
    check("t1_rd_dok", {31'b0, obs_dok[t+6]}, 32'h1);
    check("t1_rd_rdata", obs_rd[t+6], 32'hDEADBEEF);
`endif
    check("t1_last_rsp", obs_rsp[$], 32'hDEADBEEF);

    xfer(1'b1, 4'hF, 32'h10, 32'h11223344);
    xfer(1'b1, 4'b0010, 32'h10, 32'h0000AA00);
    xfer(1'b0, 4'h0, 32'h10, 32'h0);
    idle(LAT + 3);
    check("byte_merge", obs_rsp[$], 32'h1122AA44);

    xfer(1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A);
    xfer(1'b0, 4'h0, 32'h0000, 32'h0);
    idle(LAT + 3);
    check("addr_wrap", obs_rsp[$], 32'h5A5A5A5A);

    // Back-to-back reads hold req for 6 cycles to fill the queue.
    t = cyc;
    nrsp = obs_rsp.size();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 4'h0, 32'h20 + (i << 2), 32'h0, 1'b1, acc);
    idle(LAT + DEP + 4);
`ifndef RANDOM_DELAY_EN
    check("full_ao0", {31'b0, obs_ao[t]},   32'h1);
    check("full_ao3", {31'b0, obs_ao[t+3]}, 32'h1);
    check("full_ao4", {31'b0, obs_ao[t+4]}, 32'h0);
    check("full_ao5", {31'b0, obs_ao[t+5]}, 32'h1);
    check("full_nrsp", obs_rsp.size() - nrsp, 32'd5);
`endif

    for (int i = 0; i < 9; i++) xfer(1'b0, 4'h0, i << 2, 32'h0);
    idle(LAT + 3);

    // Reset with three reads in flight.
    xfer(1'b0, 4'h0, 32'h0, 32'h0);
    xfer(1'b0, 4'h0, 32'h4, 32'h0);
    xfer(1'b0, 4'h0, 32'h8, 32'h0);
    t = cyc;
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acc);
    check("rst_addr_ok", {31'b0, obs_ao[t]}, 32'h0);
    idle(LAT + 6);
    nrsp = 0;
    for (int c = t + 1; c < cyc; c++) nrsp += int'(obs_dok[c]);
    check("rst_no_dok", nrsp, 32'h0);
    xfer(1'b0, 4'h0, 32'h10, 32'h0);
    idle(LAT + 3);
    check("mem_retained", obs_rsp[$], 32'h1122AA44);

    for (int i = 0; i < 200; i++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom),
           4'($urandom), ($urandom & 32'hFFFF_F003) | ($urandom_range(0, 15) << 2),
           $urandom, 1'b1, acc);
    end
    idle(LAT + DEP + 6);
    check("drain_empty", q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
